sprite_line_scheduler: RTL and testbench

Per-scanline sprite scheduler for the game renderer. During each horizontal blank it walks the object table (chef, enemy, 16 burger layers) and builds an ordered list of up to `MAX_PER_LINE` objects that vertically intersect the next game line. The list is double-buffered, so the pixel-selection logic reads a stable list for the current line while the next one is being built.

---
 rtl/sprite_sched_pkg.sv | 30 +++
 rtl/sprite_line_scheduler_if.sv | 17 +
 rtl/sprite_line_bank.sv | 83 ++++++++
 rtl/sprite_line_scheduler.sv | 154 +++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_sched_pkg.sv
// Shared definitions for the per-scanline sprite scheduler.
//   - Object table geometry and object index assignments
//   - Field widths used by the scheduler, its list storage and its bus
//   - Scheduler FSM state encoding
package sprite_sched_pkg;

  localparam int NUM_OBJ      = 18;  // 0 = chef, 1 = enemy, 2..17 = burger layers
  localparam int MAX_PER_LINE = 8;   // list slots per line

  localparam int IDX_W  = 5;   // object index width
  localparam int Y_W    = 10;  // game-space y width
  localparam int H_W    = 5;   // object height width
  localparam int SLOT_W = 3;   // list slot address width
  localparam int CNT_W  = 4;   // list entry count width (0..8)

  localparam logic [IDX_W-1:0] OBJ_CHEF        = 5'd0;
  localparam logic [IDX_W-1:0] OBJ_ENEMY       = 5'd1;
  localparam logic [IDX_W-1:0] OBJ_BURGER_BASE = 5'd2;

  localparam int CHEF_H  = 16;
  localparam int LAYER_H = 8;
  localparam int GAME_H  = 215;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FINISH
  } sched_state_e;

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Object table fetch bus between the scheduler and the upstream table mux.
//   obj_idx   : object index requested by the scheduler
//   obj_valid : object exists / is drawn (combinational response to obj_idx)
//   obj_y     : object top y
//   obj_h     : object height (0 means the object never hits)
// Modports: master = scheduler side, slave = object table side.
interface sprite_line_scheduler_if;
  import sprite_sched_pkg::*;

  logic [IDX_W-1:0] obj_idx;
  logic             obj_valid;
  logic [Y_W-1:0]   obj_y;
  logic [H_W-1:0]   obj_h;

  modport master (output obj_idx, input obj_valid, input obj_y, input obj_h);
  modport slave  (input obj_idx, output obj_valid, output obj_y, output obj_h);
endinterface

// File: rtl/sprite_line_bank.sv
// Double-buffered sprite list storage.
//   Clk, Reset_n     : clock, asynchronous active-low reset
//   swap_i           : exchange front and back banks
//   clear_i          : empty the bank that is back after this edge
//   wr_en_i/wr_idx_i : append an object index to the back bank
//   set_ovf_i        : flag the back bank as overflowed
//   rd_slot_i        : front-bank read address
//   rd_idx_o         : front-bank entry at rd_slot_i (combinational)
//   front_count_o/front_ovf_o, back_count_o/back_ovf_o : per-bank status
module sprite_line_bank
  import sprite_sched_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              swap_i,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic              set_ovf_i,
  input  logic [SLOT_W-1:0] rd_slot_i,
  output logic [IDX_W-1:0]  rd_idx_o,
  output logic [CNT_W-1:0]  front_count_o,
  output logic              front_ovf_o,
  output logic [CNT_W-1:0]  back_count_o,
  output logic              back_ovf_o
);

  logic             front_sel_q;
  logic             front_sel_d;
  logic [IDX_W-1:0] rd_word [2];
  logic [CNT_W-1:0] count_w [2];
  logic             ovf_w   [2];

  assign front_sel_d = front_sel_q ^ swap_i;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) front_sel_q <= 1'b0;
    else          front_sel_q <= front_sel_d;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic BANK_ID = 1'(gi);

    logic [IDX_W-1:0] mem_q [MAX_PER_LINE];
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             clear_this;
    logic             is_back;

    // Clear targets the bank that will be back once any swap has taken
    // effect, so a swap+clear empties the old front bank.
    assign clear_this = clear_i && (front_sel_d != BANK_ID);
    assign is_back    = (front_sel_q != BANK_ID);

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
        for (int i = 0; i < MAX_PER_LINE; i++) mem_q[i] <= '0;
      end else if (clear_this) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (is_back) begin
        if (wr_en_i) begin
          mem_q[count_q[SLOT_W-1:0]] <= wr_idx_i;
          count_q                    <= count_q + 1'b1;
        end
        if (set_ovf_i) ovf_q <= 1'b1;
      end
    end

    assign rd_word[gi] = mem_q[rd_slot_i];
    assign count_w[gi] = count_q;
    assign ovf_w[gi]   = ovf_q;
  end

  assign rd_idx_o      = rd_word[front_sel_q];
  assign front_count_o = count_w[front_sel_q];
  assign front_ovf_o   = ovf_w[front_sel_q];
  assign back_count_o  = count_w[~front_sel_q];
  assign back_ovf_o    = ovf_w[~front_sel_q];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler. On each line_start it walks the 18-entry
// object table (one object per cycle) and builds an ascending-index list of
// up to 8 objects covering next_line into the back bank; the finished list
// becomes the front bank on the following line_start.
//   Clk, Reset_n            : clock, asynchronous active-low reset
//   line_start, next_line   : hblank pulse and the game line to build
//   obj_bus (master)        : object table fetch bus
//   rd_slot, rd_idx, rd_hit : front-bank read port (combinational)
//   front_count, overflow   : front-bank entry count and overflow flag
//   busy, done              : scan in progress / one-cycle completion pulse
//   ovf_lines               : saturating count of overflowed lines
// Build option: define SPRITE_OVF_CNT_EN to build the ovf_lines counter;
// otherwise ovf_lines is tied to 0.
module sprite_line_scheduler
  import sprite_sched_pkg::*;
(
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     line_start,
  input  logic [Y_W-1:0]           next_line,
  sprite_line_scheduler_if.master  obj_bus,
  input  logic [SLOT_W-1:0]        rd_slot,
  output logic [IDX_W-1:0]         rd_idx,
  output logic                     rd_hit,
  output logic [CNT_W-1:0]         front_count,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [7:0]               ovf_lines
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PER_LINE);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] obj_idx_q, obj_idx_d;
  logic [Y_W-1:0]   line_q, line_d;
  logic             back_complete_q, back_complete_d;

  logic             swap, clear, wr_en, set_ovf, restart, hit;
  logic [CNT_W-1:0] back_count;
  logic             back_ovf;
  logic [Y_W:0]     obj_bottom;

  // One extra bit keeps obj_y + obj_h from wrapping near the top of the range.
  assign obj_bottom = {1'b0, obj_bus.obj_y} + {{(Y_W + 1 - H_W){1'b0}}, obj_bus.obj_h};
  assign hit = obj_bus.obj_valid &&
               (line_q >= obj_bus.obj_y) &&
               ({1'b0, line_q} < obj_bottom);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q         <= IDLE;
      obj_idx_q       <= '0;
      line_q          <= '0;
      back_complete_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      obj_idx_q       <= obj_idx_d;
      line_q          <= line_d;
      back_complete_q <= back_complete_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    obj_idx_d       = obj_idx_q;
    line_d          = line_q;
    back_complete_d = back_complete_q;
    swap            = 1'b0;
    clear           = 1'b0;
    wr_en           = 1'b0;
    set_ovf         = 1'b0;
    restart         = 1'b0;
    done            = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (line_start) begin
          swap            = back_complete_q;
          back_complete_d = 1'b0;
          restart         = 1'b1;
        end
      end
      SCAN: begin
        if (line_start) begin
          restart = 1'b1;  // abandon; rebuild the same back bank
        end else begin
          wr_en     = hit && (back_count < MAX_CNT);
          set_ovf   = hit && (back_count >= MAX_CNT);
          obj_idx_d = obj_idx_q + 1'b1;
          if (obj_idx_q == LAST_IDX) state_d = FINISH;
        end
      end
      FINISH: begin
        if (line_start) begin
          restart = 1'b1;  // abandoned scans never report done
        end else begin
          done            = 1'b1;
          back_complete_d = 1'b1;
          obj_idx_d       = '0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      line_d    = next_line;
      obj_idx_d = '0;
      clear     = 1'b1;
      state_d   = SCAN;
    end
  end

  sprite_line_bank u_bank (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .swap_i        (swap),
    .clear_i       (clear),
    .wr_en_i       (wr_en),
    .wr_idx_i      (obj_idx_q),
    .set_ovf_i     (set_ovf),
    .rd_slot_i     (rd_slot),
    .rd_idx_o      (rd_idx),
    .front_count_o (front_count),
    .front_ovf_o   (overflow),
    .back_count_o  (back_count),
    .back_ovf_o    (back_ovf)
  );

  assign obj_bus.obj_idx = obj_idx_q;
  assign busy            = (state_q != IDLE);
  assign rd_hit          = ({1'b0, rd_slot} < front_count);

`ifdef SPRITE_OVF_CNT_EN
  logic [7:0] ovf_lines_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf_lines_q <= '0;
    end else if (swap && back_ovf && (ovf_lines_q != 8'hFF)) begin
      ovf_lines_q <= ovf_lines_q + 1'b1;
    end
  end

  assign ovf_lines = ovf_lines_q;
`else
  logic unused_back_ovf;
  assign unused_back_ovf = back_ovf;
  assign ovf_lines       = '0;
`endif

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler: a table of directed line
// builds followed by hand-written abort, reset and saturation sequences.
module tb_sprite_line_scheduler;
  import sprite_sched_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       line_start = 1'b0;
  logic [9:0] next_line = '0;
  logic [2:0] rd_slot = '0;
  logic [4:0] rd_idx;
  logic       rd_hit;
  logic [3:0] front_count;
  logic       busy, done, overflow;
  logic [7:0] ovf_lines;

  logic       tbl_valid [32];
  logic [9:0] tbl_y     [32];
  logic [4:0] tbl_h     [32];

  int checks = 0;
  int errors = 0;
  int exp_ovf_lines = 0;
  bit pend_valid = 1'b0;
  bit pend_ovf = 1'b0;

  typedef struct {
    logic [17:0] mask;
    logic [9:0]  y;
    logic [4:0]  h;
    logic [9:0]  line;
    int          exp_count;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs [13];

  sprite_line_scheduler_if obj_bus ();

  assign obj_bus.obj_valid = tbl_valid[obj_bus.obj_idx];
  assign obj_bus.obj_y     = tbl_y[obj_bus.obj_idx];
  assign obj_bus.obj_h     = tbl_h[obj_bus.obj_idx];

  always #10 Clk = ~Clk;

  sprite_line_scheduler dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .line_start  (line_start),
    .next_line   (next_line),
    .obj_bus     (obj_bus),
    .rd_slot     (rd_slot),
    .rd_idx      (rd_idx),
    .rd_hit      (rd_hit),
    .front_count (front_count),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .ovf_lines   (ovf_lines)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_table(input logic [17:0] mask, input logic [9:0] y, input logic [4:0] h);
    for (int i = 0; i < 32; i++) begin
      tbl_valid[i] = (i < NUM_OBJ) ? mask[i] : 1'b0;
      tbl_y[i]     = y;
      tbl_h[i]     = h;
    end
  endtask

  // Called at a falling edge; returns at the falling edge of cycle T+1.
  task automatic pulse(input logic [9:0] l);
    line_start = 1'b1;
    next_line  = l;
    if (pend_valid) begin
      if (pend_ovf && exp_ovf_lines < 255) exp_ovf_lines++;
      pend_valid = 1'b0;
    end
    @(negedge Clk);
    line_start = 1'b0;
  endtask

  // Measures falling edges from T+1 until done; done belongs at T+19.
  task automatic wait_done(input string name, input bit ovf);
    int c;
    bit found;
    c = 0;
    found = 1'b0;
    while (!found && c < 40) begin
      @(negedge Clk);
      c++;
      if (done === 1'b1) found = 1'b1;
    end
    check({name, " done latency"}, c, 18);
    pend_valid = found;
    pend_ovf   = ovf;
    @(negedge Clk);
    check({name, " busy after done"}, busy, 0);
  endtask

  task automatic check_front(input string name, input logic [17:0] mask, input int exp_count,
                             input bit exp_ovf);
    int exp_list [8];
    int n;
    n = 0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (mask[i] && n < MAX_PER_LINE) begin
        exp_list[n] = i;
        n++;
      end
    end
    check({name, " front_count"}, front_count, exp_count);
    check({name, " overflow"}, overflow, exp_ovf);
`ifdef SPRITE_OVF_CNT_EN
    check({name, " ovf_lines"}, ovf_lines, exp_ovf_lines);
`else
    check({name, " ovf_lines"}, ovf_lines, 0);
`endif
    for (int s = 0; s < MAX_PER_LINE; s++) begin
      rd_slot = 3'(s);
      #1;
      check($sformatf("%s rd_hit(%0d)", name, s), rd_hit, (s < exp_count) ? 1 : 0);
      if (s < exp_count) check($sformatf("%s rd_idx(%0d)", name, s), rd_idx, exp_list[s]);
    end
    rd_slot = '0;
  endtask

  initial begin
    logic [17:0] chef_m, layer_m;
    chef_m  = 18'd1 << OBJ_CHEF;
    layer_m = 18'd1 << OBJ_BURGER_BASE;

    vecs[0]  = '{chef_m,    10'd100,  5'(CHEF_H),  10'd107, 1, 1'b0};
    vecs[1]  = '{chef_m,    10'd100,  5'(CHEF_H),  10'd115, 1, 1'b0};
    vecs[2]  = '{chef_m,    10'd100,  5'(CHEF_H),  10'd116, 0, 1'b0};
    vecs[3]  = '{chef_m,    10'd100,  5'(CHEF_H),  10'd99,  0, 1'b0};
    vecs[4]  = '{layer_m,   10'd60,   5'(LAYER_H), 10'd67,  1, 1'b0};
    vecs[5]  = '{layer_m,   10'd60,   5'(LAYER_H), 10'd68,  0, 1'b0};
    vecs[6]  = '{18'h003FF, 10'd45,   5'd8,        10'd50,  8, 1'b1};
    vecs[7]  = '{18'h000FF, 10'd45,   5'd8,        10'd50,  8, 1'b0};
    vecs[8]  = '{18'h001FF, 10'd45,   5'd8,        10'd52,  8, 1'b1};
    vecs[9]  = '{chef_m,    10'd50,   5'd0,        10'd50,  0, 1'b0};
    vecs[10] = '{18'h20028, 10'd0,    5'd16,       10'd0,   3, 1'b0};
    vecs[11] = '{chef_m,    10'd1000, 5'd31,       10'd1010, 1, 1'b0};
    vecs[12] = '{18'h3FFFF, 10'd200,  5'd16,       10'(GAME_H - 1), 8, 1'b1};

    set_table('0, '0, '0);

    // Reset state
    repeat (2) @(negedge Clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset front_count", front_count, 0);
    check("reset overflow", overflow, 0);
    check("reset rd_hit", rd_hit, 0);
    check("reset rd_idx", rd_idx, 0);
    check("reset obj_idx", obj_bus.obj_idx, 0);
    check("reset ovf_lines", ovf_lines, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Table-driven line builds: build, swap in, inspect front bank
    for (int vi = 0; vi < 13; vi++) begin
      set_table(vecs[vi].mask, vecs[vi].y, vecs[vi].h);
      pulse(vecs[vi].line);
      check($sformatf("v%0d busy at T+1", vi), busy, 1);
      wait_done($sformatf("v%0d build", vi), vecs[vi].exp_ovf);
      pulse(vecs[vi].line);
      check_front($sformatf("v%0d", vi), vecs[vi].mask, vecs[vi].exp_count, vecs[vi].exp_ovf);
      wait_done($sformatf("v%0d rebuild", vi), vecs[vi].exp_ovf);
      $display("vector %0d line %0d: front_count %0d overflow %0d", vi, vecs[vi].line,
               front_count, overflow);
    end

    // line_start landing in FINISH abandons that scan without done
    set_table(18'd1 << OBJ_CHEF, 10'd100, 5'(CHEF_H));
    pulse(10'd100);
    repeat (18) @(negedge Clk);
    check("finish-abort done in FINISH", done, 1);
    line_start = 1'b1;
    next_line  = 10'd107;
    #1;
    check("finish-abort done suppressed", done, 0);
    @(negedge Clk);
    line_start = 1'b0;
    wait_done("finish-abort restart", 1'b0);
    pulse(10'd0);
    check_front("finish-abort", 18'd1 << OBJ_CHEF, 1, 1'b0);
    wait_done("finish-abort tail", 1'b0);
    $display("finish-abort sequence: front_count %0d", front_count);

    // Mid-scan abort: front keeps prior contents until the following line_start
    set_table(18'd1 << OBJ_CHEF, 10'd100, 5'(CHEF_H));
    pulse(10'd107);
    wait_done("abort prep", 1'b0);
    set_table(18'h003FF, 10'd15, 5'd8);
    pulse(10'd100);
    check("abort front_count after swap", front_count, 1);
    repeat (5) @(negedge Clk);
    check("abort obj_idx at T+6", obj_bus.obj_idx, 5);
    @(negedge Clk);
    pulse(10'd20);
    check("abort busy", busy, 1);
    wait_done("abort restart", 1'b1);
    check("abort front_count kept", front_count, 1);
    check("abort rd_idx kept", rd_idx, 0);
    pulse(10'd0);
    check_front("abort", 18'h003FF, 8, 1'b1);
    $display("abort sequence: front_count %0d overflow %0d", front_count, overflow);

    // Reset at T+5 of the scan started by the pulse above
    repeat (4) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset front_count", front_count, 0);
    check("midreset overflow", overflow, 0);
    check("midreset rd_hit", rd_hit, 0);
    check("midreset obj_idx", obj_bus.obj_idx, 0);
    check("midreset ovf_lines", ovf_lines, 0);
    exp_ovf_lines = 0;
    pend_valid    = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    $display("mid-scan reset: front_count %0d busy %0d", front_count, busy);

    // 300 consecutive overflowed lines
    set_table(18'h003FF, 10'd45, 5'd8);
    for (int n = 0; n < 301; n++) begin
      pulse(10'd50);
      wait_done("saturate", 1'b1);
    end
    pulse(10'd50);
`ifdef SPRITE_OVF_CNT_EN
    check("saturate ovf_lines", ovf_lines, 255);
`else
    check("saturate ovf_lines", ovf_lines, 0);
`endif
    check("saturate overflow", overflow, 1);
    $display("saturation: ovf_lines %0d", ovf_lines);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
